// File: rtl/imm_pkg.sv
// Immediate-format definitions shared by the encoder and the decode-side extend logic.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -(1 << 20);
  localparam int IMM_J_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check of a signed immediate for its format.
// Illegal formats are never rejected here; the encoder flags them separately.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [2:0]  i_src,
  input  logic [31:0] i_imm,
  output logic        o_reject
);

  logic signed [31:0] w_imm;
  imm_src_e           w_src;

  assign w_imm = $signed(i_imm);
  assign w_src = imm_src_e'(i_src);

  always_comb begin
    o_reject = 1'b0;
    case (w_src)
      IMM_I, IMM_S: o_reject = (w_imm < IMM_IS_MIN) || (w_imm > IMM_IS_MAX);
      IMM_B:        o_reject = (w_imm < IMM_B_MIN) || (w_imm > IMM_B_MAX) || i_imm[0];
      IMM_J:        o_reject = (w_imm < IMM_J_MIN) || (w_imm > IMM_J_MAX) || i_imm[0];
      IMM_U:        o_reject = (i_imm[11:0] != 12'h000);
      default:      o_reject = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encode_unit.sv
// Two-stage packer of a signed immediate into an instruction word (S1 capture/check, S2 packed word).
// Define IMM_RANGE_CHECK_EN to replace unrepresentable immediates with NOP_WORD and raise imm_err.
module imm_encode_unit
  import imm_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count
);

  logic             r_s1_vld;
  logic [2:0]       r_s1_src;
  logic [31:0]      r_s1_imm;
  logic [31:0]      r_s1_base;
  logic             r_s1_rej;
  logic             r_out_vld;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_reject;
  logic        w_illegal;
  logic [31:0] w_mask;
  logic [31:0] w_field;
  logic [31:0] w_word;

`ifdef IMM_RANGE_CHECK_EN
  imm_range_check u_range (
    .i_src    (ImmSrc),
    .i_imm    (Imm),
    .o_reject (w_reject)
  );
`else
  assign w_reject = 1'b0;
`endif

  assign w_s2_adv = !r_out_vld || out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;

  // Field holds the scattered immediate bits; everything outside the mask comes from Base.
  always_comb begin
    w_mask  = 32'h0000_0000;
    w_field = 32'h0000_0000;
    case (imm_src_e'(r_s1_src))
      IMM_I: begin
        w_mask  = 32'hFFF0_0000;
        w_field = {r_s1_imm[11:0], 20'h0_0000};
      end
      IMM_S: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {r_s1_imm[11:5], 13'h0000, r_s1_imm[4:0], 7'h00};
      end
      IMM_B: begin
        w_mask  = 32'hFE00_0F80;
        w_field = {r_s1_imm[12], r_s1_imm[10:5], 13'h0000, r_s1_imm[4:1], r_s1_imm[11], 7'h00};
      end
      IMM_J: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], 12'h000};
      end
      IMM_U: begin
        w_mask  = 32'hFFFF_F000;
        w_field = {r_s1_imm[31:12], 12'h000};
      end
      default: begin
        w_mask  = 32'h0000_0000;
        w_field = 32'h0000_0000;
      end
    endcase
  end

  assign w_illegal = (r_s1_src > IMM_U);
  assign w_word    = r_s1_rej ? NOP_WORD : ((r_s1_base & ~w_mask) | (w_field & w_mask));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_src  <= 3'b000;
      r_s1_imm  <= 32'h0000_0000;
      r_s1_base <= 32'h0000_0000;
      r_s1_rej  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_src  <= ImmSrc;
        r_s1_imm  <= Imm;
        r_s1_base <= Base;
        r_s1_rej  <= w_reject;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_instr   <= 32'h0000_0000;
      r_err     <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_instr <= w_word;
        r_err   <= r_s1_rej || w_illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_out_vld && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_vld;
  assign Instr     = r_instr;
  assign imm_err   = r_err;
  assign enc_count = r_cnt;

endmodule

// File: doc/imm_encode_unit.md
IMM_ENCODE_UNIT -- requirements
Module: imm_encode_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the encoded-instruction counter.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0013, giving the substitute word for rejected encodings.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port ImmSrc, input, 3 bits: immediate format, 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal.
REQ-008 The block SHALL have port Imm, input, 32 bits: the full signed immediate value to pack.
REQ-009 The block SHALL have port Base, input, 32 bits: the instruction word carrying opcode/rd/rs1/rs2/funct; immediate bit positions are don't-care.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Instr is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Instr.
REQ-012 The block SHALL have port Instr, output, 32 bits: the encoded instruction word.
REQ-013 The block SHALL have port imm_err, output, 1 bit: the current Instr came from a rejected request; qualified by out_valid.
REQ-014 The block SHALL have port enc_count, output, CNT_W bits: the number of completed output handshakes.

Function
REQ-015 A transfer SHALL occur on in_valid&&in_ready at input and on out_valid&&out_ready at output.
REQ-016 The pipeline SHALL have two register stages, S1 (input capture plus range check) and S2 (packed word).
- Latency: exactly 2 cycles from input handshake to out_valid with out_ready held high.
- Throughput: 1 word per cycle.
REQ-017 S2 SHALL advance when !s2_valid||out_ready; S1 SHALL advance when !s1_valid||S2 advances; in_ready SHALL equal the S1 advance condition, combinationally.
REQ-018 While stalled, Instr, imm_err and out_valid SHALL hold stable; no word may be dropped or duplicated.
REQ-019 Bit positions the format does not use SHALL be taken from Base; positions the format uses SHALL be overwritten as follows:
- I: Instr[31:20]=Imm[11:0].
- S: Instr[31:25]=Imm[11:5] and Instr[11:7]=Imm[4:0].
- B: Instr[31]=Imm[12], Instr[30:25]=Imm[10:5], Instr[11:8]=Imm[4:1] and Instr[7]=Imm[11].
- J: Instr[31]=Imm[20], Instr[30:21]=Imm[10:1], Instr[20]=Imm[11] and Instr[19:12]=Imm[19:12].
- U: Instr[31:12]=Imm[31:12].
REQ-020 For an illegal ImmSrc, the block SHALL output Instr=Base unchanged with imm_err=1.
REQ-021 enc_count SHALL increment by 1 per output handshake and wrap from 2^CNT_W-1 to 0.
REQ-022 Simultaneous input and output handshakes in one cycle SHALL be legal and sustain full throughput.

Reset
REQ-023 While rst is high, out_valid=0, imm_err=0, Instr=0, enc_count=0, in_ready=0, and both stage-valid flags SHALL be 0.
REQ-024 Asserting rst mid-operation SHALL discard in-flight words immediately, without emitting them.
REQ-025 The first input handshake after reset SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-026 With macro IMM_RANGE_CHECK_EN defined, S1 SHALL reject any request whose immediate is not representable:
- I/S: Imm outside [-2048, 2047].
- B: Imm outside [-4096, 4094], or Imm[0]=1.
- J: Imm outside [-2^20, 2^20-2], or Imm[0]=1.
- U: Imm[11:0] not zero.
A rejected request SHALL emit Instr=NOP_WORD with imm_err=1, and it SHALL still count in enc_count.
REQ-027 With IMM_RANGE_CHECK_EN undefined, out-of-range immediates SHALL be silently truncated per REQ-019, and imm_err SHALL be asserted only for an illegal ImmSrc.

Structure
REQ-028 Package imm_pkg SHALL hold:
- the ImmSrc enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U), sharing its encoding with the decode-side extend logic;
- the NOP_WORD default;
- the per-format min/max immediate constants.
REQ-029 The range check SHALL be a combinational sub-module, imm_range_check, instantiated only under IMM_RANGE_CHECK_EN.

Verification
REQ-030 I-type: Base=32'h0000_0513, Imm=-1, ImmSrc=000, out_ready=1 -> Instr=32'hFFF0_0513, imm_err=0, two cycles after the handshake.
REQ-031 B-type: Base=32'h0000_0063, Imm=-4096 -> Instr=32'h8000_0063; with the macro, Imm=3 -> Instr=32'h0000_0013, imm_err=1.
REQ-032 Back-pressure: 4 back-to-back requests with out_ready low for 3 cycles -> in_ready drops after 2 accepted, and all 4 words emerge in order without duplication.
REQ-033 Illegal ImmSrc=101 with Base=32'h1234_5678 -> Instr=32'h1234_5678, imm_err=1.
REQ-034 Counter: CNT_W=4 with 17 output handshakes -> enc_count=1; rst pulsed with 2 words in flight -> out_valid=0, enc_count=0, and no stale word after release.
